// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared widths, defaults and FSM encoding for the CORDIC phase driver
package cordic_pkg;

  localparam int ANGLE_W = 16;
  localparam int COUNT_W = 8;
  localparam int WAIT_W  = 16;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 40;

  typedef logic [ANGLE_W-1:0] angle_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_CORE,
    OUTPUT,
    FINISH
  } drv_state_e;

  typedef struct packed {
    angle_t sine;
    angle_t cosine;
  } sample_t;

endpackage

// File: rtl/cordic_phase_acc.sv
// rtl/cordic_phase_acc.sv - phase accumulator; load wins over step, step wraps modulo 2^16
module cordic_phase_acc
  import cordic_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load_i,
  input  angle_t load_value_i,
  input  logic   step_i,
  input  angle_t inc_i,
  output angle_t acc_o
);

  angle_t acc_q;
  angle_t acc_d;

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = load_value_i;
    end else if (step_i) begin
      acc_d = acc_q + inc_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/cordic_phase_driver.sv
// rtl/cordic_phase_driver.sv - sequences a phase sweep through an external CORDIC core
// and hands each sine/cosine result downstream over a valid/ready handshake.
module cordic_phase_driver
  import cordic_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ANGLE_W-1:0] phase_init,
  input  logic [ANGLE_W-1:0] phase_inc,
  input  logic [COUNT_W-1:0] num_samples,
  output logic [ANGLE_W-1:0] theta,
  output logic               theta_valid,
  input  logic               core_done,
  input  logic [ANGLE_W-1:0] core_sine,
  input  logic [ANGLE_W-1:0] core_cosine,
  output logic [ANGLE_W-1:0] sample_sine,
  output logic [ANGLE_W-1:0] sample_cosine,
  output logic [COUNT_W-1:0] sample_index,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               busy,
  output logic               done,
  output logic               timeout_err
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  drv_state_e         state_q, state_d;
  angle_t             theta_q, theta_d;
  logic               theta_valid_q, theta_valid_d;
  sample_t            sample_q, sample_d;
  logic [COUNT_W-1:0] index_q, index_d;
  logic               sample_valid_q, sample_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  angle_t             inc_q, inc_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;

  logic   acc_load;
  logic   acc_step;
  angle_t acc_value;
  logic   more_samples;

  cordic_phase_acc u_phase_acc (
    .clk          (clk),
    .reset        (reset),
    .load_i       (acc_load),
    .load_value_i (phase_init),
    .step_i       (acc_step),
    .inc_i        (inc_q),
    .acc_o        (acc_value)
  );

  // Index is compared one ahead because it increments on the same edge as the decision.
  assign more_samples = ({1'b0, index_q} + 9'd1) < {1'b0, count_q};

  always_comb begin
    state_d        = state_q;
    theta_d        = theta_q;
    theta_valid_d  = 1'b0;
    sample_d       = sample_q;
    index_d        = index_q;
    sample_valid_d = sample_valid_q;
    timeout_d      = timeout_q;
    inc_d          = inc_q;
    count_d        = count_q;
    wait_d         = wait_q;
    acc_load       = 1'b0;
    acc_step       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          inc_d     = phase_inc;
          count_d   = num_samples;
          timeout_d = 1'b0;
          index_d   = '0;
          acc_load  = 1'b1;
          state_d   = (num_samples == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        theta_d       = acc_value;
        theta_valid_d = 1'b1;
        wait_d        = '0;
        state_d       = WAIT_CORE;
      end
      WAIT_CORE: begin
        if (core_done) begin
          sample_d.sine   = core_sine;
          sample_d.cosine = core_cosine;
          sample_valid_d  = 1'b1;
          state_d         = OUTPUT;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = FINISH;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      OUTPUT: begin
        if (sample_ready) begin
          sample_valid_d = 1'b0;
          index_d        = index_q + 1'b1;
          acc_step       = 1'b1;
          state_d        = more_samples ? ISSUE : FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flags are registered from the next state so done lines up with the FINISH cycle.
    done_d = (state_d == FINISH);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      theta_q        <= '0;
      theta_valid_q  <= 1'b0;
      sample_q       <= '0;
      index_q        <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      inc_q          <= '0;
      count_q        <= '0;
      wait_q         <= '0;
    end else begin
      state_q        <= state_d;
      theta_q        <= theta_d;
      theta_valid_q  <= theta_valid_d;
      sample_q       <= sample_d;
      index_q        <= index_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      timeout_q      <= timeout_d;
      inc_q          <= inc_d;
      count_q        <= count_d;
      wait_q         <= wait_d;
    end
  end

  assign theta         = theta_q;
  assign theta_valid   = theta_valid_q;
  assign sample_sine   = sample_q.sine;
  assign sample_cosine = sample_q.cosine;
  assign sample_index  = index_q;
  assign sample_valid  = sample_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_cordic_phase_driver.sv
// tb/tb_cordic_phase_driver.sv - directed bench with a sweep-level scoreboard and a latency-17 core model
module tb_cordic_phase_driver;

  localparam int CORE_LAT = 17;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] phase_init;
  logic [15:0] phase_inc;
  logic [7:0]  num_samples;
  logic [15:0] theta;
  logic        theta_valid;
  logic        core_done;
  logic [15:0] core_sine;
  logic [15:0] core_cosine;
  logic [15:0] sample_sine;
  logic [15:0] sample_cosine;
  logic [7:0]  sample_index;
  logic        sample_valid;
  logic        sample_ready;
  logic        busy;
  logic        done;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int cyc = 0;
  int spur_cyc = -1;
  bit core_en = 1'b1;
  bit core_real = 1'b0;

  logic [15:0] exp_theta[$];
  logic [39:0] exp_samp[$];

  cordic_phase_driver #(.TIMEOUT_CYCLES(40)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .phase_init    (phase_init),
    .phase_inc     (phase_inc),
    .num_samples   (num_samples),
    .theta         (theta),
    .theta_valid   (theta_valid),
    .core_done     (core_done),
    .core_sine     (core_sine),
    .core_cosine   (core_cosine),
    .sample_sine   (sample_sine),
    .sample_cosine (sample_cosine),
    .sample_index  (sample_index),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .busy          (busy),
    .done          (done),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] model_angle(input logic [15:0] init, input logic [15:0] inc, input int k);
    return init + 16'(k) * inc;
  endfunction

  function automatic logic [15:0] model_sine(input logic [15:0] t);
    return t ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] model_cos(input logic [15:0] t);
    return ~t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic plan(input logic [15:0] init, input logic [15:0] inc, input int n, input bit with_samples);
    for (int k = 0; k < n; k++) begin
      logic [15:0] a;
      a = model_angle(init, inc, k);
      exp_theta.push_back(a);
      if (with_samples) exp_samp.push_back({model_sine(a), model_cos(a), 8'(k)});
    end
  endtask

  task automatic do_start(input logic [15:0] init, input logic [15:0] inc, input logic [7:0] n);
    phase_init  = init;
    phase_inc   = inc;
    num_samples = n;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check(name, seen, 1);
  endtask

  // Core model: answers each theta_valid after CORE_LAT cycles; spur_cyc injects a stray done.
  initial begin
    int          cnt;
    logic [15:0] held;
    cnt = 0;
    held = '0;
    core_done = 1'b0;
    core_sine = '0;
    core_cosine = '0;
    forever begin
      @(posedge clk);
      #2;
      core_done = 1'b0;
      core_real = 1'b0;
      if (reset) begin
        cnt = 0;
      end else if (cnt != 0) begin
        cnt--;
        if (cnt == 0) begin
          core_done   = 1'b1;
          core_real   = 1'b1;
          core_sine   = model_sine(held);
          core_cosine = model_cos(held);
        end
      end else if (theta_valid && core_en) begin
        held = theta;
        cnt  = CORE_LAT;
      end
      if (cyc == spur_cyc && !core_done) begin
        core_done   = 1'b1;
        core_sine   = 16'hDEAD;
        core_cosine = 16'hBEEF;
      end
    end
  end

  // Compare process: checks every cycle against the sweep plan and the handshake rules.
  initial begin
    bit          have_prev, prev_hold, prev_real, prev_done;
    logic [15:0] prev_theta;
    logic [39:0] prev_data;
    have_prev = 0; prev_hold = 0; prev_real = 0; prev_done = 0;
    prev_theta = '0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        have_prev = 0; prev_hold = 0; prev_real = 0; prev_done = 0;
      end else begin
        if (theta_valid) begin
          check("theta_valid_expected", exp_theta.size() != 0, 1);
          if (exp_theta.size() != 0) check("theta", theta, exp_theta.pop_front());
          check("issue_while_sample_held", sample_valid, 0);
        end else if (have_prev) begin
          check("theta_hold", theta, prev_theta);
        end
        if (prev_hold) begin
          check("hold_valid", sample_valid, 1);
          check("hold_data", {sample_sine, sample_cosine, sample_index}, prev_data);
        end
        if (prev_real) check("done_to_valid_latency", sample_valid, 1);
        if (core_real) check("valid_before_core_done", sample_valid, 0);
        if (sample_valid && sample_ready) begin
          check("sample_expected", exp_samp.size() != 0, 1);
          if (exp_samp.size() != 0)
            check("sample", {sample_sine, sample_cosine, sample_index}, exp_samp.pop_front());
        end
        if (done) begin
          done_cnt++;
          check("done_width", prev_done, 0);
          check("done_busy", busy, 1);
        end
        if (theta_valid || sample_valid) check("active_busy", busy, 1);
        have_prev  = 1;
        prev_theta = theta;
        prev_hold  = sample_valid && !sample_ready;
        prev_data  = {sample_sine, sample_cosine, sample_index};
        prev_real  = core_real;
        prev_done  = done;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    int d0;
    int cnt;
    bit seen;
    reset = 1'b1;
    start = 1'b0;
    phase_init = '0;
    phase_inc = '0;
    num_samples = '0;
    sample_ready = 1'b1;
    repeat (2) tick();
    check("rst_theta", theta, 0);
    check("rst_flags", {theta_valid, sample_valid, busy, done, timeout_err}, 0);
    check("rst_sample", {sample_sine, sample_cosine, sample_index}, 0);
    reset = 1'b0;
    tick();

    // Four-step quarter-turn sweep
    plan(16'h0000, 16'h4000, 4, 1);
    d0 = done_cnt;
    do_start(16'h0000, 16'h4000, 8'd4);
    check("t1_busy_after_start", busy, 1);
    check("t1_latency_cycle1", theta_valid, 0);
    tick();
    check("t1_latency_cycle2", theta_valid, 1);
    wait_done(300, "t1_done_seen");
    check("t1_timeout_clear", timeout_err, 0);
    tick();
    check("t1_busy_idle", busy, 0);
    check("t1_last_theta", theta, 16'hC000);
    check("t1_index_end", sample_index, 8'd4);
    check("t1_last_sine", sample_sine, 16'h9A5A);
    check("t1_last_cosine", sample_cosine, 16'h3FFF);
    repeat (3) tick();
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_theta_left", exp_theta.size(), 0);
    check("t1_samples_left", exp_samp.size(), 0);

    // Accumulator wrap
    plan(16'hF000, 16'h2000, 2, 1);
    d0 = done_cnt;
    do_start(16'hF000, 16'h2000, 8'd2);
    wait_done(200, "t2_done_seen");
    repeat (2) tick();
    check("t2_last_theta", theta, 16'h1000);
    check("t2_index_end", sample_index, 8'd2);
    check("t2_done_pulses", done_cnt - d0, 1);
    check("t2_samples_left", exp_samp.size(), 0);

    // Backpressure with a stray core_done while the sample is held
    sample_ready = 1'b0;
    plan(16'h1234, 16'h0100, 2, 1);
    d0 = done_cnt;
    do_start(16'h1234, 16'h0100, 8'd2);
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      tick();
      if (sample_valid) seen = 1'b1;
    end
    check("t3_first_sample_seen", seen, 1);
    spur_cyc = cyc + 3;
    repeat (10) tick();
    check("t3_still_held", {sample_valid, sample_index}, {1'b1, 8'd0});
    check("t3_held_sine", sample_sine, 16'h486E);
    sample_ready = 1'b1;
    wait_done(200, "t3_done_seen");
    tick();
    check("t3_last_theta", theta, 16'h1334);
    check("t3_index_end", sample_index, 8'd2);
    check("t3_done_pulses", done_cnt - d0, 1);
    check("t3_samples_left", exp_samp.size(), 0);

    // Core never answers
    core_en = 1'b0;
    plan(16'h0500, 16'h0100, 1, 0);
    d0 = done_cnt;
    do_start(16'h0500, 16'h0100, 8'd3);
    tick();
    check("t4_issued", theta_valid, 1);
    cnt = 0;
    seen = 1'b0;
    while (cnt < 100 && !seen) begin
      tick();
      cnt++;
      if (done) seen = 1'b1;
    end
    check("t4_wait_cycles", cnt, 40);
    check("t4_timeout_err", timeout_err, 1);
    repeat (3) tick();
    check("t4_timeout_sticky", timeout_err, 1);
    check("t4_idle", {busy, sample_valid}, 0);
    check("t4_done_pulses", done_cnt - d0, 1);
    check("t4_theta_left", exp_theta.size(), 0);
    core_en = 1'b1;

    // Zero-length sweep
    d0 = done_cnt;
    do_start(16'h7777, 16'h0001, 8'd0);
    check("t5_done_next_cycle", done, 1);
    check("t5_timeout_cleared", timeout_err, 0);
    check("t5_no_issue", theta_valid, 0);
    tick();
    check("t5_done_width", {done, busy}, 0);
    check("t5_theta_held", theta, 16'h0500);
    tick();
    check("t5_done_pulses", done_cnt - d0, 1);

    // Stray core_done while idle
    spur_cyc = cyc + 1;
    repeat (4) tick();
    check("t6_idle_spur_ignored", {sample_valid, busy}, 0);

    // Start while busy is ignored
    plan(16'h0800, 16'h0010, 1, 1);
    d0 = done_cnt;
    do_start(16'h0800, 16'h0010, 8'd1);
    repeat (3) tick();
    phase_init = 16'hAAAA;
    num_samples = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(200, "t6_done_seen");
    tick();
    check("t6_last_theta", theta, 16'h0800);
    check("t6_index_end", sample_index, 8'd1);
    repeat (3) tick();
    check("t6_done_pulses", done_cnt - d0, 1);
    check("t6_theta_left", exp_theta.size(), 0);

    // Reset while waiting on the core
    plan(16'h3000, 16'h1000, 3, 1);
    do_start(16'h3000, 16'h1000, 8'd3);
    repeat (6) tick();
    check("t7_in_wait", {busy, theta_valid, sample_valid}, 3'b100);
    reset = 1'b1;
    #1;
    check("t7_rst_theta", theta, 0);
    check("t7_rst_flags", {theta_valid, sample_valid, busy, done, timeout_err}, 0);
    check("t7_rst_sample", {sample_sine, sample_cosine, sample_index}, 0);
    tick();
    tick();
    reset = 1'b0;
    exp_theta.delete();
    exp_samp.delete();
    d0 = done_cnt;
    repeat (30) tick();
    check("t7_no_done_after_reset", done_cnt - d0, 0);
    check("t7_stays_idle", {busy, theta_valid, sample_valid}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_phase_driver.md
CORDIC_PHASE_DRIVER -- requirements
Module: cordic_phase_driver

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, single-cycle request to begin a sweep; sampled only in IDLE.
REQ-004 SHALL have port phase_init, input, 16, first angle of the sweep; captured on accepted start.
REQ-005 SHALL have port phase_inc, input, 16, per-sample angle step; captured on accepted start.
REQ-006 SHALL have port num_samples, input, 8, sweep length; captured on accepted start.
REQ-007 SHALL have port theta, output, 16, angle presented to the CORDIC core.
REQ-008 SHALL have port theta_valid, output, 1, one-cycle issue strobe to the core's i_valid.
REQ-009 SHALL have port core_done, input, 1, completion strobe from the CORDIC core.
REQ-010 SHALL have ports core_sine and core_cosine, input, 16 each, CORDIC results, valid when core_done=1.
REQ-011 SHALL have ports sample_sine and sample_cosine, output, 16 each, registered results.
REQ-012 SHALL have port sample_index, output, 8, zero-based index of the held sample.
REQ-013 SHALL have ports sample_valid (output, 1) and sample_ready (input, 1), forming the downstream handshake.
REQ-014 SHALL have ports busy (output, 1), done (output, 1-cycle pulse) and timeout_err (output, 1, sticky until next accepted start).
REQ-015 SHALL have parameter TIMEOUT_CYCLES, default 40, maximum WAIT_CORE cycles before abort.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT_CORE, OUTPUT, FINISH.
REQ-017 SHALL, in IDLE with start=1, capture phase_init/phase_inc/num_samples, clear timeout_err and sample counter, and go to ISSUE; num_samples=0 SHALL go directly to FINISH.
REQ-018 SHALL, in ISSUE, drive theta=phase accumulator and theta_valid=1 for exactly one cycle, then go to WAIT_CORE.
REQ-019 SHALL, in WAIT_CORE, on core_done=1 register core_sine/core_cosine into sample_sine/sample_cosine, set sample_valid, and go to OUTPUT.
REQ-020 SHALL ignore core_done in every state except WAIT_CORE.
REQ-021 SHALL count WAIT_CORE cycles; on reaching TIMEOUT_CYCLES without core_done, set timeout_err and go to FINISH without emitting a sample.
REQ-022 SHALL hold sample_valid, sample data and sample_index stable in OUTPUT until sample_ready=1; a transfer completes in the cycle sample_valid&sample_ready=1.
REQ-023 SHALL, on transfer, add phase_inc to the accumulator modulo 2^16 (wrap, no saturation), increment sample_index, clear sample_valid, and go to ISSUE if more samples remain, else FINISH.
REQ-024 SHALL, in FINISH, pulse done for one cycle and return to IDLE.
REQ-025 SHALL drive busy=1 in every state except IDLE.
REQ-026 SHALL ignore start in every state other than IDLE.
REQ-027 SHALL hold theta at the last issued angle when theta_valid=0.
REQ-028 SHALL give a start-to-first-theta_valid latency of exactly 2 cycles, and a core_done-to-sample_valid latency of 1 cycle.

Reset
REQ-029 SHALL, on reset=1, asynchronously force state IDLE and set theta, sample_sine, sample_cosine, sample_index, phase accumulator and counters to 0.
REQ-030 SHALL, on reset=1, force theta_valid, sample_valid, busy, done and timeout_err to 0.
REQ-031 SHALL abandon any sweep when reset is asserted mid-operation, with no done pulse on release.

Structure
REQ-032 SHALL take the state encoding, the 16-bit angle width and the TIMEOUT_CYCLES default from a shared package cordic_pkg.
REQ-033 SHALL place the phase accumulator, with load and step controls, in a single sub-module cordic_phase_acc; all other logic SHALL remain flat.

Verification
REQ-034 Sweep: phase_init=0x0000, phase_inc=0x4000, num_samples=4, core model done after 17 cycles, ready held at 1 -> theta sequence 0x0000, 0x4000, 0x8000, 0xC000; indices 0..3; one done pulse.
REQ-035 Wrap: phase_init=0xF000, phase_inc=0x2000, num_samples=2 -> theta 0xF000 then 0x1000.
REQ-036 Backpressure: sample_ready low for 10 cycles -> sample_valid, data and index held stable; no new theta_valid until transfer.
REQ-037 Timeout: core model never asserts done -> timeout_err=1 after 40 WAIT_CORE cycles; done pulse; sample_valid never asserted.
REQ-038 Edge cases: num_samples=0 -> done pulse 1 cycle after start with no theta_valid; start asserted while busy -> ignored; reset in WAIT_CORE -> all outputs 0, no done pulse.
